// File: rtl/config_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// config_loader: buffers host config packets and sequences the mesh load/run phases.
// Optional LOADER_TIMEOUT_EN aborts a LOAD stalled on an empty FIFO.  Rev 1.0
// ---------------------------------------------------------------------------
module config_loader #(
    parameter int          FIFO_DEPTH     = 8,
    parameter int          DRAIN_CYCLES   = 8,
    parameter int          ENTRY_PORT     = 0,
    parameter logic [47:0] BUBBLE         = 48'h0,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] run_cycles,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [47:0] cfg_data,
    input  logic        cfg_last,
    output logic        load,
    output logic [1:0]  in_flag,
    output logic [47:0] out_config,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] c_drain_last = DW'(DRAIN_CYCLES - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        DRAIN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("config_loader: unsupported parameter values");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [48:0]     r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            r_last_seen;
    logic [DW-1:0]   r_drain_cnt;
    logic [15:0]     r_run_left;
    logic [47:0]     r_out_config;
    logic            r_error;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [48:0]     w_head;
    logic            w_err_set;
    logic            w_timeout;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    assign cfg_ready = reset && ((r_state == ST_IDLE) || (r_state == ST_LOAD)) &&
                       !w_full && !r_last_seen;
    assign w_push    = cfg_valid && cfg_ready;
    assign w_pop     = (r_state == ST_LOAD) && !w_empty;

    assign load       = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
    assign in_flag    = load ? 2'(ENTRY_PORT) : 2'd0;
    assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done       = (r_state == ST_DONE);
    assign out_config = r_out_config;
    assign error      = r_error;

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] c_to_last = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_to_cnt;

    // Counts consecutive empty LOAD cycles; any pop leaves LOAD-empty and clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if ((r_state == ST_LOAD) && w_empty) begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == ST_LOAD) && w_empty && (r_to_cnt == c_to_last);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {cfg_last, cfg_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || w_timeout) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_empty && !r_last_seen) begin
                        w_next    = ST_DRAIN;
                        w_err_set = 1'b1;
                    end else begin
                        w_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (w_pop && w_head[48]) begin
                    w_next = ST_DRAIN;
                end else if (w_timeout) begin
                    w_next    = ST_DONE;
                    w_err_set = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == c_drain_last) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (r_run_left <= 16'd1) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_seen  <= 1'b0;
            r_drain_cnt  <= '0;
            r_run_left   <= '0;
            r_out_config <= BUBBLE;
            r_error      <= 1'b0;
        end else begin
            if (r_state == ST_DONE) begin
                r_last_seen <= 1'b0;
            end else if (w_push && cfg_last) begin
                r_last_seen <= 1'b1;
            end
            r_drain_cnt  <= (r_state == ST_DRAIN) ? r_drain_cnt + DW'(1) : '0;
            // run_cycles of 0 and 1 both give a single RUN cycle.
            if ((r_state == ST_IDLE) && start) begin
                r_run_left <= run_cycles;
            end else if ((r_state == ST_RUN) && (r_run_left != 16'd0)) begin
                r_run_left <= r_run_left - 16'd1;
            end
            r_out_config <= w_pop ? w_head[47:0] : BUBBLE;
            r_error      <= r_error | w_err_set;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// tb_config_loader: directed self-checking bench for config_loader.
module tb_config_loader;

    localparam logic [47:0] BUB = 48'hFFFF_0000_BEEF;
    localparam logic [47:0] PRE [3] = '{48'h80_6_3_1111_0001, 48'h40_9_7_2222_0002, 48'h00_A_C_3333_0003};
    localparam logic [47:0] SA = 48'h11_1_1_AAAA_0001;
    localparam logic [47:0] SB = 48'h22_2_2_BBBB_0002;
    localparam logic [47:0] SC = 48'h33_3_3_CCCC_0003;
    localparam logic [47:0] SD = 48'h44_4_4_DDDD_0004;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] run_cycles;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [47:0] cfg_data;
    logic        cfg_last;
    logic        load;
    logic [1:0]  in_flag;
    logic [47:0] out_config;
    logic        busy;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    config_loader #(
        .FIFO_DEPTH(8), .DRAIN_CYCLES(8), .ENTRY_PORT(1), .BUBBLE(BUB), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
        .load(load), .in_flag(in_flag), .out_config(out_config),
        .busy(busy), .done(done), .error(error)
    );

    function automatic logic [47:0] pkt(input int k);
        return {k[7:0], 2'b01, 2'b10, 4'h5, 16'hC0DE, k[15:0]};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; run_cycles = '0;
        cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
        repeat (2) tick();
        checks++; if ({load, in_flag} !== 3'b000) begin errors++; $display("FAIL reset_load_flag: got %b want 000", {load, in_flag}); end
        checks++; if (out_config !== BUB) begin errors++; $display("FAIL reset_out_config: got %h want %h", out_config, BUB); end
        checks++; if ({cfg_ready, busy, done, error} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {cfg_ready, busy, done, error}); end
        reset = 1'b1;
        tick();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", cfg_ready); end
    endtask

    task automatic test_preload();
        logic [47:0] exp_out;
        logic [53:0] exp_vec;
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1; cfg_data = PRE[i]; cfg_last = (i == 2);
            tick();
        end
        cfg_valid = 1'b0; cfg_last = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL preload_last_seen_ready: got %b want 0", cfg_ready); end
        start = 1'b1; run_cycles = 16'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            exp_out = BUB;
            if (i >= 1 && i <= 3) exp_out = PRE[i-1];
            exp_vec = {(i <= 10), ((i <= 10) ? 2'd1 : 2'd0), exp_out, (i == 16), (i <= 15), 1'b0};
            checks++;
            if ({load, in_flag, out_config, done, busy, error} !== exp_vec) begin
                errors++;
                $display("FAIL preload_cycle%0d: got %h want %h (load,in_flag,out_config,done,busy,error)",
                         i, {load, in_flag, out_config, done, busy, error}, exp_vec);
            end
            if (i < 17) tick();
        end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL preload_idle_ready: got %b want 1", cfg_ready); end
    endtask

    task automatic test_stream();
        int  k = 0;
        int  out_idx = 0;
        int  dones = 0;
        bit  accepted = 1'b0;
        bit  started = 1'b0;
        for (int cyc = 0; cyc < 120 && dones == 0; cyc++) begin
            if (accepted) k++;
            if (load && out_config !== BUB) begin
                checks++;
                if (out_config !== pkt(out_idx)) begin
                    errors++; $display("FAIL stream_order%0d: got %h want %h", out_idx, out_config, pkt(out_idx));
                end
                out_idx++;
            end
            if (done) dones++;
            start = 1'b0;
            if (!started && k == 8) begin
                checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL stream_full_ready: got %b want 0", cfg_ready); end
                start = 1'b1; run_cycles = 16'd3; started = 1'b1;
            end
            cfg_valid = (k < 20); cfg_data = pkt(k); cfg_last = (k == 19);
            accepted  = cfg_ready && cfg_valid;
            tick();
        end
        cfg_valid = 1'b0; cfg_last = 1'b0; start = 1'b0;
        checks++; if (out_idx != 20) begin errors++; $display("FAIL stream_count: got %0d want 20", out_idx); end
        checks++; if (dones != 1) begin errors++; $display("FAIL stream_done: got %0d want 1", dones); end
        checks++; if ({busy, error} !== 2'b00) begin errors++; $display("FAIL stream_end_busy_error: got %b want 00", {busy, error}); end
    endtask

    task automatic test_stall();
        int nl = 0;
        int nd = 0;
        cfg_valid = 1'b1; cfg_data = SA; cfg_last = 1'b0;
        tick();
        cfg_valid = 1'b0; start = 1'b1; run_cycles = 16'd2;
        tick();
        start = 1'b0;
        checks++; if ({load, out_config} !== {1'b1, BUB}) begin errors++; $display("FAIL stall_first_load: got %h want %h", {load, out_config}, {1'b1, BUB}); end
        tick();
        checks++; if (out_config !== SA) begin errors++; $display("FAIL stall_inject_a: got %h want %h", out_config, SA); end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_config, load, busy, done} !== {BUB, 3'b110}) begin
                errors++; $display("FAIL stall_bubble%0d: got %h want %h", i, {out_config, load, busy, done}, {BUB, 3'b110});
            end
            if (i <= 2) begin
                checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL stall_in_load%0d: got %b want 1", i, cfg_ready); end
            end
            cfg_valid = (i == 2); cfg_data = SB; cfg_last = (i == 2);
            tick();
        end
        checks++; if ({load, out_config} !== {1'b1, SB}) begin errors++; $display("FAIL stall_inject_b: got %h want %h", {load, out_config}, {1'b1, SB}); end
        for (int c = 0; c < 30 && nd == 0; c++) begin
            if (load) nl++;
            if (done) nd++;
            tick();
        end
        checks++; if (nl != 8) begin errors++; $display("FAIL stall_drain_len: got %0d want 8", nl); end
        checks++; if ({nd[0], error} !== 2'b10) begin errors++; $display("FAIL stall_done_error: got %b want 10", {nd[0], error}); end
    endtask

    task automatic test_reset_mid();
        int nl = 0;
        int nd = 0;
        int nr = 0;
        cfg_valid = 1'b1; cfg_data = SC; cfg_last = 1'b1;
        tick();
        cfg_valid = 1'b0; cfg_last = 1'b0; start = 1'b1; run_cycles = 16'd1;
        tick();
        start = 1'b0;
        tick();
        checks++; if ({load, out_config} !== {1'b1, SC}) begin errors++; $display("FAIL rstmid_inject: got %h want %h", {load, out_config}, {1'b1, SC}); end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({load, in_flag, busy, done, cfg_ready, out_config} !== {6'b000000, BUB}) begin
            errors++; $display("FAIL rstmid_abort: got %h want %h", {load, in_flag, busy, done, cfg_ready, out_config}, {6'b000000, BUB});
        end
        reset = 1'b1;
        tick();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", cfg_ready); end
        cfg_valid = 1'b1; cfg_data = SD; cfg_last = 1'b1;
        tick();
        cfg_valid = 1'b0; cfg_last = 1'b0; start = 1'b1; run_cycles = 16'd1;
        tick();
        start = 1'b0;
        tick();
        checks++; if ({load, out_config} !== {1'b1, SD}) begin errors++; $display("FAIL rstmid_fresh_inject: got %h want %h", {load, out_config}, {1'b1, SD}); end
        for (int c = 0; c < 30 && nd == 0; c++) begin
            if (load) nl++;
            if (busy && !load) nr++;
            if (done) nd++;
            tick();
        end
        checks++; if (nl != 8) begin errors++; $display("FAIL rstmid_drain_len: got %0d want 8", nl); end
        checks++; if (nr != 1) begin errors++; $display("FAIL rstmid_run_len: got %0d want 1", nr); end
        checks++; if ({nd[0], error} !== 2'b10) begin errors++; $display("FAIL rstmid_done_error: got %b want 10", {nd[0], error}); end
    endtask

    task automatic test_empty_start();
        int nl = 0;
        int nd = 0;
        int nr = 0;
        start = 1'b1; run_cycles = 16'd0;
        tick();
        start = 1'b0;
        checks++;
        if ({error, load, busy, cfg_ready, out_config} !== {4'b1110, BUB}) begin
            errors++; $display("FAIL empty_enter_drain: got %h want %h", {error, load, busy, cfg_ready, out_config}, {4'b1110, BUB});
        end
        for (int c = 0; c < 30 && nd == 0; c++) begin
            if (load) nl++;
            if (busy && !load) nr++;
            if (done) nd++;
            start = (c == 1);
            tick();
        end
        start = 1'b0;
        checks++; if (nl != 8) begin errors++; $display("FAIL empty_drain_len: got %0d want 8", nl); end
        checks++; if (nr != 1) begin errors++; $display("FAIL empty_run_len: got %0d want 1", nr); end
        checks++; if (nd != 1) begin errors++; $display("FAIL empty_done: got %0d want 1", nd); end
        repeat (3) tick();
        checks++; if ({busy, error} !== 2'b01) begin errors++; $display("FAIL empty_sticky_idle: got %b want 01", {busy, error}); end
    endtask

`ifdef LOADER_TIMEOUT_EN
    task automatic test_timeout();
        int done_at = -1;
        int nr = 0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cfg_valid = 1'b1; cfg_data = SA; cfg_last = 1'b0;
        tick();
        cfg_valid = 1'b0; start = 1'b1; run_cycles = 16'd4;
        tick();
        start = 1'b0;
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            if (busy && !load) nr++;
            if (done) begin
                done_at = c;
                checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b want 1", error); end
            end
            tick();
        end
        checks++; if (done_at != 17) begin errors++; $display("FAIL timeout_latency: got %0d want 17", done_at); end
        checks++; if (nr != 0) begin errors++; $display("FAIL timeout_no_run: got %0d want 0", nr); end
        checks++; if ({load, busy} !== 2'b00) begin errors++; $display("FAIL timeout_idle: got %b want 00", {load, busy}); end
    endtask
`endif

    initial begin
        test_reset();
        test_preload();
        test_stream();
        test_stall();
        test_reset_mid();
        test_empty_start();
`ifdef LOADER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
